cdc_fifo_write_ctrl: RTL and testbench

//   Write-domain pointer and flag controller for a dual-clock asynchronous FIFO.

---
 rtl/cdc_fifo_write_ctrl.sv | 103 ++++++++++
 tb/tb_cdc_fifo_write_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_write_ctrl.sv
// Write-domain pointer and flag controller for a dual-clock asynchronous FIFO.
// Holds the binary write pointer, publishes its registered Gray copy to the read
// domain, synchronizes the read pointer in, and derives full / almost_full /
// free_count / sticky overflow against the synchronized (possibly stale) read pointer.
module cdc_fifo_write_ctrl #(
    parameter int ADDRESS_WIDTH         = 4,
    parameter int SYNC_STAGES           = 2,
    parameter int ALMOST_FULL_THRESHOLD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_request,
    input  logic                     clear_overflow,
    input  logic [ADDRESS_WIDTH:0]   read_pointer_gray,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
    output logic                     full,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH:0]   free_count,
    output logic                     overflow
);

    localparam int                   PW        = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH     = PW'(1) << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] THRESHOLD = PW'(ALMOST_FULL_THRESHOLD);

    function automatic logic [ADDRESS_WIDTH:0] bin_to_gray(input logic [ADDRESS_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDRESS_WIDTH:0] gray_to_bin(input logic [ADDRESS_WIDTH:0] g);
        logic [ADDRESS_WIDTH:0] b;
        b[ADDRESS_WIDTH] = g[ADDRESS_WIDTH];
        for (int i = ADDRESS_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRESS_WIDTH:0] wp;
    logic [ADDRESS_WIDTH:0] wp_next;
    logic [ADDRESS_WIDTH:0] rp;
    logic [ADDRESS_WIDTH:0] used;
    logic [ADDRESS_WIDTH:0] sync_chain [SYNC_STAGES];

    // Read-pointer synchronizer: a pure flop chain, no logic between stages.
    // NOTE: every stage is reset, so a freshly reset FIFO never sees a garbage
    // read pointer that could fake a full or non-empty condition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
        end else begin
            sync_chain[0] <= read_pointer_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i - 1];
            end
        end
    end

    // Flag and occupancy logic from the write pointer and the synchronized read pointer.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        rp           = gray_to_bin(sync_chain[SYNC_STAGES - 1]);
        used         = wp - rp;
        full         = (wp[ADDRESS_WIDTH] != rp[ADDRESS_WIDTH]) &&
                       (wp[ADDRESS_WIDTH-1:0] == rp[ADDRESS_WIDTH-1:0]);
        free_count   = DEPTH - used;
        almost_full  = (free_count <= THRESHOLD);
        write_enable = write_request && !full;
        wp_next      = wp + PW'(write_enable);
    end

    assign write_address = wp[ADDRESS_WIDTH-1:0];

    // Write pointer and its Gray copy advance together, so the Gray output is
    // a clean register that changes exactly one bit per accepted write.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp                 <= '0;
            write_pointer_gray <= '0;
        end else begin
            wp                 <= wp_next;
            write_pointer_gray <= bin_to_gray(wp_next);
        end
    end

    // Sticky overflow: a dropped write sets it, and setting wins over clearing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (write_request && full) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_write_ctrl.sv
// Directed bench for cdc_fifo_write_ctrl: a default instance (AW=4, 2 sync stages)
// and a small one (AW=2, 3 sync stages). Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_cdc_fifo_write_ctrl;

    logic       clock;

    logic       reset_a, req_a, clr_a;
    logic [4:0] rpg_a;
    logic       we_a, full_a, af_a, ovf_a;
    logic [3:0] addr_a;
    logic [4:0] wpg_a, free_a;

    logic       reset_b, req_b, clr_b;
    logic [2:0] rpg_b;
    logic       we_b, full_b, af_b, ovf_b;
    logic [1:0] addr_b;
    logic [2:0] wpg_b, free_b;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    int unsigned sb_a [$];
    int unsigned sb_b [$];

    cdc_fifo_write_ctrl #(.ADDRESS_WIDTH(4), .SYNC_STAGES(2), .ALMOST_FULL_THRESHOLD(2)) dut_a (
        .clock(clock), .reset(reset_a), .write_request(req_a), .clear_overflow(clr_a),
        .read_pointer_gray(rpg_a), .write_enable(we_a), .write_address(addr_a),
        .write_pointer_gray(wpg_a), .full(full_a), .almost_full(af_a),
        .free_count(free_a), .overflow(ovf_a)
    );

    cdc_fifo_write_ctrl #(.ADDRESS_WIDTH(2), .SYNC_STAGES(3), .ALMOST_FULL_THRESHOLD(2)) dut_b (
        .clock(clock), .reset(reset_b), .write_request(req_b), .clear_overflow(clr_b),
        .read_pointer_gray(rpg_b), .write_enable(we_b), .write_address(addr_b),
        .write_pointer_gray(wpg_b), .full(full_b), .almost_full(af_b),
        .free_count(free_b), .overflow(ovf_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic drive_a(input logic req, input logic clr, input logic [4:0] rpg);
        @(negedge clock);
        req_a = req; clr_a = clr; rpg_a = rpg;
        #1;
    endtask

    task automatic drive_b(input logic req, input logic clr, input logic [2:0] rpg);
        @(negedge clock);
        req_b = req; clr_b = clr; rpg_b = rpg;
        #1;
    endtask

    // Compare the RAM address of an accepted write against the oldest expected entry.
    task automatic pop_a(input string tag);
        int unsigned exp;
        if (we_a) begin
            exp = (sb_a.size() != 0) ? sb_a.pop_front() : 32'hDEAD;
            check(tag, 32'(addr_a), exp);
        end
    endtask

    task automatic pop_b(input string tag);
        int unsigned exp;
        if (we_b) begin
            exp = (sb_b.size() != 0) ? sb_b.pop_front() : 32'hDEAD;
            check(tag, 32'(addr_b), exp);
        end
    endtask

    initial begin
        int wa;
        int wb;
        int rp_src;
        logic [4:0] prev_gray;

        reset_a = 1'b1; req_a = 1'b0; clr_a = 1'b0; rpg_a = '0;
        reset_b = 1'b1; req_b = 1'b0; clr_b = 1'b0; rpg_b = '0;
        wa = 0; wb = 0;

        // 1: reset state of the default instance
        #3;
        check("rst_full", 32'(full_a), 0);
        check("rst_free", 32'(free_a), 16);
        check("rst_af", 32'(af_a), 0);
        check("rst_gray", 32'(wpg_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        @(negedge clock);
        reset_a = 1'b0; reset_b = 1'b0;

        // 2 + 5: fill 16 entries with the read pointer parked at 0
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b1, 1'b0, 5'd0);
            if (i == 13) begin
                check("af_at13", 32'(af_a), 0);
                check("free_at13", 32'(free_a), 3);
            end
            if (i == 14) begin
                check("af_at14", 32'(af_a), 1);
                check("free_at14", 32'(free_a), 2);
            end
            sb_a.push_back(32'(wa & 15));
            check("fill_we", 32'(we_a), 1);
            pop_a("fill_addr");
            wa++;
        end
        drive_a(1'b1, 1'b0, 5'd0);
        check("full_16", 32'(full_a), 1);
        check("free_16", 32'(free_a), 0);
        check("we_when_full", 32'(we_a), 0);
        check("ovf_not_yet", 32'(ovf_a), 0);
        drive_a(1'b0, 1'b0, 5'd0);
        check("ovf_set", 32'(ovf_a), 1);
        check("full_hold", 32'(full_a), 1);

        // 3: read pointer 0 -> 1, full must drop exactly two edges later
        drive_a(1'b0, 1'b0, gray5(1));
        check("lat_e0_full", 32'(full_a), 1);
        drive_a(1'b0, 1'b0, gray5(1));
        check("lat_e1_full", 32'(full_a), 1);
        drive_a(1'b0, 1'b0, gray5(1));
        check("lat_e2_full", 32'(full_a), 0);
        check("lat_e2_free", 32'(free_a), 1);
        drive_a(1'b1, 1'b0, gray5(1));
        sb_a.push_back(32'(wa & 15));
        check("refill_we", 32'(we_a), 1);
        pop_a("refill_addr");
        wa++;
        drive_a(1'b1, 1'b1, gray5(1));
        check("refull", 32'(full_a), 1);
        check("refull_we", 32'(we_a), 0);
        drive_a(1'b0, 1'b1, gray5(1));
        check("ovf_set_wins", 32'(ovf_a), 1);
        drive_a(1'b0, 1'b0, gray5(1));
        check("ovf_cleared", 32'(ovf_a), 0);

        // 4: continuous writes with the read pointer 3 behind; wraps 31 -> 0
        @(negedge clock);
        reset_a = 1'b1; req_a = 1'b0; rpg_a = '0;
        sb_a.delete();
        wa = 0;
        @(negedge clock);
        reset_a = 1'b0;
        prev_gray = wpg_a;
        for (int k = 0; k < 40; k++) begin
            rp_src = (k >= 3) ? k - 3 : 0;
            drive_a(1'b1, 1'b0, gray5(rp_src));
            check("wrap_gray", 32'(wpg_a), 32'(gray5(k)));
            if (k > 0) check("wrap_1bit", $countones(prev_gray ^ wpg_a), 1);
            check("wrap_not_full", 32'(full_a), 0);
            sb_a.push_back(32'(k & 15));
            check("wrap_we", 32'(we_a), 1);
            pop_a("wrap_addr");
            prev_gray = wpg_a;
        end

        // 6: asynchronous reset in the middle of a burst at wp=9
        @(negedge clock);
        reset_a = 1'b1; req_a = 1'b0; rpg_a = '0;
        sb_a.delete();
        @(negedge clock);
        reset_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_a(1'b1, 1'b0, 5'd0);
        end
        drive_a(1'b1, 1'b0, 5'd0);
        check("mid_addr9", 32'(addr_a), 9);
        reset_a = 1'b1;
        #1;
        check("mid_rst_gray", 32'(wpg_a), 0);
        check("mid_rst_addr", 32'(addr_a), 0);
        check("mid_rst_free", 32'(free_a), 16);
        check("mid_rst_full", 32'(full_a), 0);
        check("mid_rst_af", 32'(af_a), 0);
        check("mid_rst_ovf", 32'(ovf_a), 0);
        @(negedge clock);
        reset_a = 1'b0; req_a = 1'b0;

        // Small instance: DEPTH=4, three-stage synchronizer
        check("b_rst_free", 32'(free_b), 4);
        check("b_rst_af", 32'(af_b), 0);
        check("b_rst_full", 32'(full_b), 0);
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b1, 1'b0, 3'd0);
            if (i == 1) check("b_af_at1", 32'(af_b), 0);
            if (i == 2) check("b_af_at2", 32'(af_b), 1);
            sb_b.push_back(32'(wb & 3));
            check("b_fill_we", 32'(we_b), 1);
            pop_b("b_fill_addr");
            wb++;
        end
        drive_b(1'b1, 1'b0, 3'd0);
        check("b_full", 32'(full_b), 1);
        check("b_free0", 32'(free_b), 0);
        check("b_we_full", 32'(we_b), 0);
        drive_b(1'b0, 1'b0, 3'd0);
        check("b_ovf_set", 32'(ovf_b), 1);
        drive_b(1'b0, 1'b0, 3'b001);
        check("b_lat_e0", 32'(full_b), 1);
        drive_b(1'b0, 1'b0, 3'b001);
        check("b_lat_e1", 32'(full_b), 1);
        drive_b(1'b0, 1'b0, 3'b001);
        check("b_lat_e2", 32'(full_b), 1);
        drive_b(1'b0, 1'b0, 3'b001);
        check("b_lat_e3", 32'(full_b), 0);
        check("b_lat_free", 32'(free_b), 1);
        drive_b(1'b1, 1'b0, 3'b001);
        sb_b.push_back(32'(wb & 3));
        check("b_refill_we", 32'(we_b), 1);
        pop_b("b_refill_addr");
        wb++;
        drive_b(1'b1, 1'b1, 3'b001);
        check("b_refull", 32'(full_b), 1);
        drive_b(1'b0, 1'b0, 3'b001);
        check("b_ovf_wins", 32'(ovf_b), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
